qeciphy_rx_link_monitor: RTL and testbench

QECIPHY_RX_LINK_MONITOR -- requirements
Module: qeciphy_rx_link_monitor

---
 rtl/qeciphy_rx_link_monitor.sv | 141 ++++++++++++++
 tb/tb_qeciphy_rx_link_monitor.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_rx_link_monitor.sv
// QECIPHY RX link monitor: comma lock acquisition, payload
// forwarding and windowed code-error supervision.
module qeciphy_rx_link_monitor #(
    parameter int LOCK_COUNT = 16,
    parameter int ERR_LIMIT  = 4,
    parameter int ERR_WINDOW = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_datapath_ready,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_ctrl_k,
    input  logic [3:0]  rx_disp_err,
    input  logic [3:0]  rx_not_in_table,
    input  logic        rx_byteisaligned,
    output logic        comma_align_en,
    output logic        rx_locked,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic [15:0] err_total,
    output logic [7:0]  realign_count
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_ALIGN,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    localparam logic [7:0]  LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0]  ERR_LIM   = 8'(ERR_LIMIT);
    localparam logic [15:0] WIN_LAST  = 16'(ERR_WINDOW - 1);

    state_t      state;
    logic [7:0]  good_cnt;
    logic [15:0] win_cnt;
    logic [7:0]  win_err;

    logic        code_err;
    logic        is_comma;
    logic        is_data;
    logic        win_wrap;
    logic [7:0]  win_err_nxt;
    logic        err_hit;

    // Classify the incoming word and precompute the window error update.
    always_comb begin
        code_err    = |(rx_disp_err | rx_not_in_table);
        is_comma    = !code_err && (rx_ctrl_k == 4'b0001)
                      && (rx_data[7:0] == 8'hBC);
        is_data     = !code_err && (rx_ctrl_k == 4'b0000);
        win_wrap    = (win_cnt == WIN_LAST);
        win_err_nxt = win_wrap ? 8'd0 : win_err;
        if (code_err) begin
            win_err_nxt = win_err_nxt + 8'd1;
        end
        err_hit     = code_err && (win_err_nxt >= ERR_LIM);
    end

    // Link FSM with registered status outputs and datapath register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_RESET;
            good_cnt       <= 8'd0;
            win_cnt        <= 16'd0;
            win_err        <= 8'd0;
            comma_align_en <= 1'b0;
            rx_locked      <= 1'b0;
            m_tdata        <= 32'h0;
            m_tvalid       <= 1'b0;
            err_total      <= 16'h0;
            realign_count  <= 8'h0;
        end else begin
            m_tvalid <= 1'b0;
            if (!rx_datapath_ready) begin
                state          <= ST_RESET;
                good_cnt       <= 8'd0;
                win_cnt        <= 16'd0;
                win_err        <= 8'd0;
                comma_align_en <= 1'b0;
                rx_locked      <= 1'b0;
            end else begin
                case (state)
                    ST_RESET: begin
                        state          <= ST_ALIGN;
                        comma_align_en <= 1'b1;
                    end
                    ST_ALIGN: begin
                        if (rx_byteisaligned && is_comma) begin
                            state          <= ST_CHECK;
                            good_cnt       <= 8'd1;
                            comma_align_en <= 1'b0;
                        end
                    end
                    ST_CHECK: begin
                        if (code_err || !rx_byteisaligned) begin
                            state          <= ST_ALIGN;
                            good_cnt       <= 8'd0;
                            comma_align_en <= 1'b1;
                        end else if (is_comma) begin
                            if (good_cnt == LOCK_LAST) begin
                                state     <= ST_LOCKED;
                                good_cnt  <= 8'd0;
                                rx_locked <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + 8'd1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (code_err && (err_total != 16'hFFFF)) begin
                            err_total <= err_total + 16'd1;
                        end
                        if (!rx_byteisaligned || err_hit) begin
                            state          <= ST_ALIGN;
                            win_cnt        <= 16'd0;
                            win_err        <= 8'd0;
                            comma_align_en <= 1'b1;
                            rx_locked      <= 1'b0;
                            if (realign_count != 8'hFF) begin
                                realign_count <= realign_count + 8'd1;
                            end
                        end else begin
                            win_cnt <= win_wrap ? 16'd0 : win_cnt + 16'd1;
                            win_err <= win_err_nxt;
                            if (is_data) begin
                                m_tvalid <= 1'b1;
                                m_tdata  <= rx_data;
                            end
                        end
                    end
                    default: begin
                        state <= ST_RESET;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qeciphy_rx_link_monitor.sv
// Randomized bench for qeciphy_rx_link_monitor checked against a
// word-level behavioural model of the link rules.
module tb_qeciphy_rx_link_monitor;

    localparam int LC = 16;
    localparam int EL = 4;
    localparam int EW = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_datapath_ready;
    logic [31:0] rx_data;
    logic [3:0]  rx_ctrl_k;
    logic [3:0]  rx_disp_err;
    logic [3:0]  rx_not_in_table;
    logic        rx_byteisaligned;
    logic        comma_align_en;
    logic        rx_locked;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic [15:0] err_total;
    logic [7:0]  realign_count;

    int vectors = 0;
    int miscompares = 0;

    // model: 0 reset, 1 align, 2 check, 3 locked
    int          md;
    int          good;
    int          nword;
    int          cur_id;
    int          errs;
    logic        e_tv;
    logic [31:0] e_td;
    int          e_et;
    int          e_rc;

    always #5 clk = ~clk;

    qeciphy_rx_link_monitor #(
        .LOCK_COUNT(LC),
        .ERR_LIMIT (EL),
        .ERR_WINDOW(EW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_datapath_ready(rx_datapath_ready),
        .rx_data          (rx_data),
        .rx_ctrl_k        (rx_ctrl_k),
        .rx_disp_err      (rx_disp_err),
        .rx_not_in_table  (rx_not_in_table),
        .rx_byteisaligned (rx_byteisaligned),
        .comma_align_en   (comma_align_en),
        .rx_locked        (rx_locked),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .err_total        (err_total),
        .realign_count    (realign_count)
    );

    function automatic logic [58:0] dut_snap();
        return {comma_align_en, rx_locked, m_tvalid, m_tdata,
                err_total, realign_count};
    endfunction

    function automatic logic [58:0] exp_snap();
        return {(md == 1), (md == 3), e_tv, e_td, 16'(e_et), 8'(e_rc)};
    endfunction

    task automatic model_reset();
        md = 0; good = 0; nword = 0; cur_id = 0; errs = 0;
        e_tv = 1'b0; e_td = 32'h0; e_et = 0; e_rc = 0;
    endtask

    // Apply one word for one clock and advance the reference model.
    task automatic step(input logic [31:0] d, input logic [3:0] k,
                        input logic [3:0] de, input logic [3:0] nit,
                        input logic al, input logic rdy);
        logic err, cm, dt, leave;
        int   id;
        rx_data = d; rx_ctrl_k = k; rx_disp_err = de;
        rx_not_in_table = nit; rx_byteisaligned = al;
        rx_datapath_ready = rdy;
        @(posedge clk);
        #1;
        err   = ((de | nit) != 4'h0);
        cm    = !err && (k == 4'b0001) && (d[7:0] == 8'hBC);
        dt    = !err && (k == 4'b0000);
        leave = 1'b0;
        e_tv  = 1'b0;
        if (!rdy) begin
            md = 0; good = 0; nword = 0; cur_id = 0; errs = 0;
        end else begin
            case (md)
                0: md = 1;
                1: if (al && cm) begin md = 2; good = 1; end
                2: begin
                    if (err || !al) begin
                        md = 1; good = 0;
                    end else if (cm) begin
                        good++;
                        if (good == LC) begin
                            md = 3; nword = 0; cur_id = 0; errs = 0;
                        end
                    end
                end
                default: begin
                    if (err && e_et < 65535) e_et++;
                    if (!al) begin
                        leave = 1'b1;
                    end else begin
                        if (dt) begin e_tv = 1'b1; e_td = d; end
                        // a window's last word already belongs to the next one
                        id = (nword + 1) / EW;
                        if (id != cur_id) begin cur_id = id; errs = 0; end
                        if (err) errs++;
                        nword++;
                        if (errs >= EL) leave = 1'b1;
                    end
                    if (leave) begin
                        md = 1;
                        if (e_rc < 255) e_rc++;
                    end
                end
            endcase
        end
    endtask

    // kind: 0 comma, 1 data, 2 other K, 3 code error
    task automatic word(input int kind, input logic al, input logic rdy);
        logic [31:0] r;
        logic [3:0]  k, de, nit;
        r = $urandom;
        k = 4'h0; de = 4'h0; nit = 4'h0;
        case (kind)
            0: begin r[7:0] = 8'hBC; k = 4'b0001; end
            1: k = 4'b0000;
            2: k = 4'($urandom_range(2, 15));
            default: begin
                k   = 4'($urandom_range(0, 15));
                de  = 4'($urandom_range(1, 15));
                nit = 4'($urandom_range(0, 15));
            end
        endcase
        step(r, k, de, nit, al, rdy);
    endtask

    task automatic relock();
        word(1, 1'b1, 1'b0);
        word(1, 1'b1, 1'b1);
        for (int i = 0; i < LC; i++) word(0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_datapath_ready = 1'b0; rx_data = 32'h0; rx_ctrl_k = 4'h0;
        rx_disp_err = 4'h0; rx_not_in_table = 4'h0;
        rx_byteisaligned = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dut_snap() !== 59'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", dut_snap());
        end
        #3 rst = 1'b0;
        word(1, 1'b1, 1'b0);
        vectors++;
        if (dut_snap() !== exp_snap()) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h",
                     dut_snap(), exp_snap());
        end
    endtask

    task automatic test_lock_acquire();
        word(1, 1'b1, 1'b1);
        vectors++;
        if (comma_align_en !== 1'b1) begin
            miscompares++;
            $display("FAIL align_entry: cae %b want 1", comma_align_en);
        end
        for (int i = 0; i < LC; i++) begin
            step(32'h0000_00BC, 4'b0001, 4'h0, 4'h0, 1'b1, 1'b1);
            vectors++;
            if (dut_snap() !== exp_snap()
                || comma_align_en !== 1'b0
                || rx_locked !== (i == LC - 1)) begin
                miscompares++;
                $display("FAIL lock_acq comma %0d: got %h want %h",
                         i, dut_snap(), exp_snap());
            end
        end
    endtask

    task automatic test_lock_abort();
        word(1, 1'b1, 1'b0);
        word(1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) word(0, 1'b1, 1'b1);
        step(32'h0000_00BC, 4'b0001, 4'b0100, 4'h0, 1'b1, 1'b1);
        vectors++;
        if (comma_align_en !== 1'b1 || dut_snap() !== exp_snap()) begin
            miscompares++;
            $display("FAIL lock_abort: got %h want %h",
                     dut_snap(), exp_snap());
        end
        for (int i = 0; i < LC; i++) begin
            word(0, 1'b1, 1'b1);
            vectors++;
            if (rx_locked !== (i == LC - 1)
                || dut_snap() !== exp_snap()) begin
                miscompares++;
                $display("FAIL relock comma %0d: got %h want %h",
                         i, dut_snap(), exp_snap());
            end
        end
    endtask

    task automatic test_data_path();
        logic [31:0] wd [3];
        logic [3:0]  wk [3];
        logic        vt [3];
        wd[0] = 32'hDEADBEEF; wk[0] = 4'b0000; vt[0] = 1'b1;
        wd[1] = 32'h0000_00BC; wk[1] = 4'b0001; vt[1] = 1'b0;
        wd[2] = 32'h12345678; wk[2] = 4'b0000; vt[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(wd[i], wk[i], 4'h0, 4'h0, 1'b1, 1'b1);
            vectors++;
            if (m_tvalid !== vt[i] || (vt[i] && m_tdata !== wd[i])
                || dut_snap() !== exp_snap()) begin
                miscompares++;
                $display("FAIL data_path word %0d: got %h want %h",
                         i, dut_snap(), exp_snap());
            end
        end
    endtask

    task automatic test_err_window();
        int p [4];
        int j;
        p[0] = $urandom_range(0, 20);
        for (int i = 1; i < 4; i++) p[i] = p[i-1] + 1 + $urandom_range(0, 20);
        j = 0;
        for (int i = 0; i < 100; i++) begin
            if (j < 4 && i == p[j]) begin
                word(3, 1'b1, 1'b1);
                j++;
            end else begin
                word($urandom_range(0, 1), 1'b1, 1'b1);
            end
            vectors++;
            if (dut_snap() !== exp_snap()) begin
                miscompares++;
                $display("FAIL err_burst word %0d: got %h want %h",
                         i, dut_snap(), exp_snap());
            end
            if (i == p[3]) begin
                vectors++;
                if (rx_locked !== 1'b0 || comma_align_en !== 1'b1
                    || realign_count !== 8'd1 || err_total !== 16'd4) begin
                    miscompares++;
                    $display("FAIL err_limit: lk %b cae %b rc %0d et %0d want 0 1 1 4",
                             rx_locked, comma_align_en,
                             realign_count, err_total);
                end
            end
        end
        relock();
        for (int w = 0; w < 3; w++) begin
            p[0] = $urandom_range(0, 300);
            p[1] = p[0] + 1 + $urandom_range(0, 300);
            p[2] = p[1] + 1 + $urandom_range(0, 300);
            j = 0;
            for (int i = 0; i < EW; i++) begin
                if (j < 3 && i == p[j]) begin
                    word(3, 1'b1, 1'b1);
                    j++;
                end else begin
                    word($urandom_range(0, 2), 1'b1, 1'b1);
                end
                vectors++;
                if (dut_snap() !== exp_snap()) begin
                    miscompares++;
                    $display("FAIL err_sustain w%0d word %0d: got %h want %h",
                             w, i, dut_snap(), exp_snap());
                end
            end
        end
        vectors++;
        if (rx_locked !== 1'b1 || err_total !== 16'd13
            || realign_count !== 8'd1) begin
            miscompares++;
            $display("FAIL err_sustain_end: lk %b et %0d rc %0d want 1 13 1",
                     rx_locked, err_total, realign_count);
        end
    endtask

    task automatic test_ready_drop();
        logic [15:0] et0;
        logic [7:0]  rc0;
        et0 = err_total;
        rc0 = realign_count;
        word(1, 1'b1, 1'b0);
        vectors++;
        if (rx_locked !== 1'b0 || m_tvalid !== 1'b0
            || comma_align_en !== 1'b0 || err_total !== et0
            || realign_count !== rc0 || dut_snap() !== exp_snap()) begin
            miscompares++;
            $display("FAIL ready_drop: got %h want %h",
                     dut_snap(), exp_snap());
        end
        word(0, 1'b1, 1'b1);
        vectors++;
        if (comma_align_en !== 1'b1 || dut_snap() !== exp_snap()) begin
            miscompares++;
            $display("FAIL ready_return: got %h want %h",
                     dut_snap(), exp_snap());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) word(0, 1'b1, 1'b1);
        vectors++;
        if (dut_snap() !== exp_snap()) begin
            miscompares++;
            $display("FAIL pre_async: got %h want %h",
                     dut_snap(), exp_snap());
        end
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (dut_snap() !== 59'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 0", dut_snap());
        end
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int   r;
        int   kind;
        logic al, rdy;
        for (int i = 0; i < 3000; i++) begin
            r    = $urandom_range(0, 99);
            kind = (r < 1) ? 3 : (r < 45) ? 0 : (r < 90) ? 1 : 2;
            al   = ($urandom_range(0, 99) != 0);
            rdy  = ($urandom_range(0, 199) != 0);
            word(kind, al, rdy);
            vectors++;
            if (dut_snap() !== exp_snap()) begin
                miscompares++;
                $display("FAIL random step %0d: got %h want %h",
                         i, dut_snap(), exp_snap());
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_lock_abort();
        test_data_path();
        test_err_window();
        test_ready_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
